vend_dispense_arbiter: RTL
==========================

VEND_DISPENSE_ARBITER -- requirements
Module: vend_dispense_arbiter

Interface
REQ-001 SHALL have parameter PRICE0, default 4'd3, price of item 0.
REQ-002 SHALL have parameter PRICE1, default 4'd5, price of item 1.
REQ-003 SHALL have parameter PRICE2, default 4'd7, price of item 2.
REQ-004 SHALL have parameter PRICE3, default 4'd9, price of item 3.
REQ-005 SHALL have parameter TIMEOUT, default 16, max cycles in DISP awaiting disp_done (used only with VEND_TIMEOUT_EN).
REQ-006 SHALL have ports: clk in 1, single clock, all logic on rising edge; rst in 1, reset, synchronous and active-high.
REQ-007 SHALL have ports: req in 2, per-panel vend request; item0/item1 in 2 each, panel item select; credit0/credit1 in 4 each, panel inserted money.
REQ-008 SHALL have ports: grant out 2, one-hot owner; disp_go out 1, dispense start pulse; disp_item out 2, item to dispense; disp_done in 1, dispenser complete.
REQ-009 SHALL have ports: ack out 2, per-panel success pulse; nak out 2, per-panel reject pulse; change out 4, refund amount; state out 2, FSM state; fault out 1, sticky dispenser timeout.

Function
REQ-010 SHALL implement FSM IDLE=2'd0, CHECK=2'd1, DISP=2'd2, DONE=2'd3; all outputs registered.
REQ-011 IDLE: if req!=0 at an edge, SHALL latch winner's item and credit, set grant one-hot to winner, and enter CHECK on that edge.
REQ-012 Arbitration SHALL be round-robin: single requester wins; both requesting -> winner is the panel not served last; after reset panel 0 has priority.
REQ-013 Round-robin pointer SHALL update only when a transaction ends (ack or nak), not on grant.
REQ-014 CHECK lasts exactly one cycle: credit>=price(item) -> DISP with disp_go=1; else nak[winner] pulses one cycle, grant clears, back to IDLE.
REQ-015 disp_go SHALL be high only in the first DISP cycle; disp_item SHALL hold the latched item throughout DISP, else 2'd0.
REQ-016 disp_done SHALL be sampled only in DISP (including the disp_go cycle) and ignored in IDLE, CHECK and DONE.
REQ-017 disp_done=1 in DISP -> DONE; in DONE ack[winner]=1 and change=credit-price for exactly one cycle, then IDLE with grant=0, change=0.
REQ-018 Comparison and subtraction SHALL be unsigned 4-bit; change cannot underflow since DISP requires credit>=price; PRICEn=0 gives change=credit.
REQ-019 req, item and credit SHALL be ignored outside IDLE; mid-transaction changes do not affect the latched values.
REQ-020 A request still high on return to IDLE SHALL be re-arbitrated as new; no panel served twice while the other waits.
REQ-021 state output SHALL equal the current FSM encoding.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE from any state, including mid-DISP, on that edge.
REQ-023 Reset values: grant=0, disp_go=0, disp_item=0, ack=0, nak=0, change=0, state=0, fault=0, RR priority to panel 0, latched item/credit=0.

Configuration
REQ-024 Macro VEND_TIMEOUT_EN, when defined, SHALL add a DISP cycle counter: after TIMEOUT cycles without disp_done -> nak[winner] one-cycle pulse, fault=1 (sticky until rst), IDLE, RR pointer updated.
REQ-025 Without VEND_TIMEOUT_EN, DISP SHALL wait for disp_done indefinitely, fault SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-026 req=2'b01, item0=1, credit0=8 -> grant=01 next cycle; disp_go pulse, disp_item=1; disp_done -> ack=01, change=3 for one cycle.
REQ-027 req=2'b10, item1=3, credit1=4 -> CHECK then nak=10 one cycle, disp_go never high, state back to 0.
REQ-028 req=2'b11 held after reset, credits sufficient, done 2 cycles after go -> grants alternate 01,10,01 across successive transactions.
REQ-029 rst=1 in DISP after disp_go -> all outputs 0, state=0 next cycle; later disp_done=1 in IDLE causes no ack.
REQ-030 VEND_TIMEOUT_EN, TIMEOUT=16, disp_done held 0 -> nak after 16 DISP cycles, fault=1 until rst; without macro state stays 2 and fault=0.

Source files
------------

// File: rtl/vend_dispense_arbiter_if.sv
// Panel/dispenser bus for the two-panel vending dispense arbiter.
// The master drives requests and dispenser completion; the slave is the arbiter.
interface vend_dispense_arbiter_if;
  logic [1:0] req;
  logic [1:0] item0;
  logic [1:0] item1;
  logic [3:0] credit0;
  logic [3:0] credit1;
  logic [1:0] grant;
  logic       disp_go;
  logic [1:0] disp_item;
  logic       disp_done;
  logic [1:0] ack;
  logic [1:0] nak;
  logic [3:0] change;
  logic [1:0] state;
  logic       fault;

  modport master (
    output req, item0, item1, credit0, credit1, disp_done,
    input  grant, disp_go, disp_item, ack, nak, change, state, fault
  );

  modport slave (
    input  req, item0, item1, credit0, credit1, disp_done,
    output grant, disp_go, disp_item, ack, nak, change, state, fault
  );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter granting one of two vending panels access to a shared dispenser.
// Optional dispenser watchdog enabled by defining VEND_TIMEOUT_EN.
module vend_dispense_arbiter #(
  parameter logic [3:0]  PRICE0  = 4'd3,
  parameter logic [3:0]  PRICE1  = 4'd5,
  parameter logic [3:0]  PRICE2  = 4'd7,
  parameter logic [3:0]  PRICE3  = 4'd9,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  vend_dispense_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StDisp  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       disp_go_q, disp_go_d;
  logic [1:0] disp_item_q, disp_item_d;
  logic [1:0] ack_q, ack_d;
  logic [1:0] nak_q, nak_d;
  logic [3:0] change_q, change_d;
  logic [1:0] item_q, item_d;
  logic [3:0] credit_q, credit_d;
  logic       win_q, win_d;
  logic       prio_q, prio_d;
  logic       win_new;
  logic [3:0] price;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;
`endif

  always_comb begin
    unique case (item_q)
      2'd0:    price = PRICE0;
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      default: price = PRICE3;
    endcase
  end

  // A lone requester always wins; on contention the priority pointer decides.
  assign win_new = (bus.req == 2'b10) ? 1'b1 : (bus.req == 2'b01) ? 1'b0 : prio_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    disp_go_d   = 1'b0;
    disp_item_d = 2'd0;
    ack_d       = 2'b00;
    nak_d       = 2'b00;
    change_d    = 4'd0;
    item_d      = item_q;
    credit_d    = credit_q;
    win_d       = win_q;
    prio_d      = prio_q;
`ifdef VEND_TIMEOUT_EN
    cnt_d       = '0;
    fault_d     = fault_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req != 2'b00) begin
          win_d    = win_new;
          item_d   = win_new ? bus.item1 : bus.item0;
          credit_d = win_new ? bus.credit1 : bus.credit0;
          grant_d  = win_new ? 2'b10 : 2'b01;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (credit_q >= price) begin
          disp_go_d   = 1'b1;
          disp_item_d = item_q;
          state_d     = StDisp;
        end else begin
          nak_d   = win_q ? 2'b10 : 2'b01;
          grant_d = 2'b00;
          prio_d  = ~win_q;
          state_d = StIdle;
        end
      end
      StDisp: begin
        if (bus.disp_done) begin
          ack_d    = win_q ? 2'b10 : 2'b01;
          change_d = credit_q - price;
          prio_d   = ~win_q;
          state_d  = StDone;
        end else begin
          disp_item_d = item_q;
`ifdef VEND_TIMEOUT_EN
          if (cnt_q == CntW'(TIMEOUT - 1)) begin
            nak_d       = win_q ? 2'b10 : 2'b01;
            grant_d     = 2'b00;
            prio_d      = ~win_q;
            fault_d     = 1'b1;
            disp_item_d = 2'd0;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      disp_go_q   <= 1'b0;
      disp_item_q <= 2'd0;
      ack_q       <= 2'b00;
      nak_q       <= 2'b00;
      change_q    <= 4'd0;
      item_q      <= 2'd0;
      credit_q    <= 4'd0;
      win_q       <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      disp_go_q   <= disp_go_d;
      disp_item_q <= disp_item_d;
      ack_q       <= ack_d;
      nak_q       <= nak_d;
      change_q    <= change_d;
      item_q      <= item_d;
      credit_q    <= credit_d;
      win_q       <= win_d;
      prio_q      <= prio_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.disp_go   = disp_go_q;
  assign bus.disp_item = disp_item_q;
  assign bus.ack       = ack_q;
  assign bus.nak       = nak_q;
  assign bus.change    = change_q;
  assign bus.state     = state_q;

endmodule
